// File: rtl/mm2s_pkg.sv
// Shared types and length helpers for the MM2S stream transmitter.
// Helpers take the beat-width log2 so any power-of-2 byte lane count up to 32 works.
package mm2s_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int LEN_W_DEF  = 16;
    localparam int KEEP_W_DEF = DATA_W_DEF / 8;

    typedef logic [KEEP_W_DEF-1:0] keep_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } tx_state_e;

    // Beats needed to carry len bytes; the 33-bit sum keeps a near-max length from wrapping.
    function automatic logic [31:0] len_to_beats(input logic [31:0] len,
                                                 input int unsigned keep_log2);
        logic [32:0] w_sum;
        w_sum = {1'b0, len} + ((33'd1 << keep_log2) - 33'd1);
        return 32'(w_sum >> keep_log2);
    endfunction

    // Byte enables for the final beat: full when len is a whole number of beats.
    function automatic logic [31:0] len_to_last_keep(input logic [31:0] len,
                                                     input int unsigned keep_log2);
        logic [31:0] w_keep_w;
        logic [31:0] w_rem;
        w_keep_w = 32'd1 << keep_log2;
        w_rem    = len & (w_keep_w - 32'd1);
        if (w_rem == 32'd0) begin
            return (32'd1 << w_keep_w) - 32'd1;
        end
        return (32'd1 << w_rem) - 32'd1;
    endfunction

endpackage

// File: rtl/mm2s_axis_tx.sv
// Pops MM2S read-data FIFO words and emits one AXI4-Stream packet per length command.
// Optional beat counter on stat_beats is built only when MM2S_AXIS_TX_STATS_EN is defined.
module mm2s_axis_tx
    import mm2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                fifo_pop_valid,
    output logic                fifo_pop_ready,
    input  logic [DATA_W-1:0]   fifo_pop_data,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                busy,
    output logic                done,
    output logic [31:0]         stat_beats,
    output logic [1:0]          o_dbg_state
);

    localparam int KEEP_W    = DATA_W / 8;
    localparam int KEEP_LOG2 = $clog2(KEEP_W);

    // Handshakes: a transfer happens on any edge where valid && ready; a producer
    // holding valid keeps its payload stable until that edge.
    tx_state_e             r_state;
    tx_state_e             w_next_state;
    logic [LEN_W:0]        r_beats_left;
    logic [KEEP_W-1:0]     r_last_keep;
    logic                  r_tvalid;
    logic [DATA_W-1:0]     r_tdata;
    logic [KEEP_W-1:0]     r_tkeep;
    logic                  r_tlast;
    logic                  r_done;

    logic                  w_cmd_accept;
    logic                  w_load;
    logic                  w_final_load;
    logic                  w_beat_acc;
    logic [31:0]           w_beats_full;
    logic [31:0]           w_keep_full;
    logic                  w_unused_bits;

    assign w_beats_full  = len_to_beats(32'(cmd_len), KEEP_LOG2);
    assign w_keep_full   = len_to_last_keep(32'(cmd_len), KEEP_LOG2);
    assign w_unused_bits = ^{w_beats_full[31:LEN_W+1], w_keep_full[31:KEEP_W]};

    assign cmd_ready      = (r_state == IDLE);
    assign w_cmd_accept   = cmd_valid && cmd_ready;
    // Pop only when the output register is free or draining this cycle.
    assign fifo_pop_ready = (r_state == STREAM) && (r_beats_left != '0) &&
                            (!r_tvalid || m_axis_tready);
    assign w_load         = fifo_pop_valid && fifo_pop_ready;
    assign w_final_load   = w_load && (r_beats_left == (LEN_W+1)'(1));
    assign w_beat_acc     = r_tvalid && m_axis_tready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cmd_accept && (cmd_len != '0)) w_next_state = STREAM;
            STREAM:  if (w_final_load) w_next_state = FLUSH;
            FLUSH:   if (w_beat_acc) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beats_left <= '0;
            r_last_keep  <= '0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cmd_accept) begin
                r_beats_left <= w_beats_full[LEN_W:0];
                r_last_keep  <= w_keep_full[KEEP_W-1:0];
                if (cmd_len == '0) r_done <= 1'b1;
            end else if (w_load) begin
                r_beats_left <= r_beats_left - (LEN_W+1)'(1);
            end

            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= fifo_pop_data;
                r_tlast  <= w_final_load;
                r_tkeep  <= w_final_load ? r_last_keep : '1;
            end else if (w_beat_acc) begin
                r_tvalid <= 1'b0;
            end

            if ((r_state == FLUSH) && w_beat_acc) r_done <= 1'b1;
        end
    end

`ifdef MM2S_AXIS_TX_STATS_EN
    logic [31:0] r_stat_beats;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_beats <= '0;
        end else if (w_beat_acc) begin
            r_stat_beats <= r_stat_beats + 32'd1;
        end
    end

    assign stat_beats = r_stat_beats;
`else
    assign stat_beats = '0;
`endif

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mm2s_axis_tx.sv
// Directed + randomized bench for mm2s_axis_tx with a queue-based packet model.
// Honours MM2S_AXIS_TX_STATS_EN when checking stat_beats.
module tb_mm2s_axis_tx;
  import mm2s_pkg::*;

  localparam int DW = 64;
  localparam int LW = 16;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          fifo_pop_valid;
  logic          fifo_pop_ready;
  logic [DW-1:0] fifo_pop_data;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic [31:0]   stat_beats;
  logic [1:0]    o_dbg_state;

  mm2s_axis_tx #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .fifo_pop_valid(fifo_pop_valid), .fifo_pop_ready(fifo_pop_ready),
    .fifo_pop_data(fifo_pop_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .stat_beats(stat_beats), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]   fifo_q[$];
  logic [DW+KW:0]  exp_q[$];
  logic [DW+KW+1:0] prev_out;
  bit   prev_stall = 0;
  bit   done_exp = 0;
  bit   rand_ready = 0;
  bit   rand_gaps = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   pkt_beats = 0;
  int   pkt_pops = 0;
  int   valid_cycles = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  int   model_stat = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat();
`ifdef MM2S_AXIS_TX_STATS_EN
    return 32'(model_stat);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [KW-1:0] model_last_keep(input int len);
    int rem;
    rem = len % KW;
    if (rem == 0) return 8'hFF;
    return 8'hFF >> (KW - rem);
  endfunction

  task automatic drive_fifo();
    fifo_pop_valid = (fifo_q.size() > 0) && (!rand_gaps || ($urandom_range(0, 1) == 1));
    fifo_pop_data  = (fifo_q.size() > 0) ? fifo_q[0] : {$urandom, $urandom};
  endtask

  // One cycle: observe at negedge, then update drivers just after posedge.
  task automatic step();
    bit pop_now;
    bit cmd_seen;
    pop_now = 0;
    cmd_seen = 0;
    @(negedge clk);
    cyc++;
    if (prev_stall)
      chk("stall_hold", 128'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
          128'(prev_out));
    chk("done", 128'(done), 128'(done_exp));
    if (done) done_cnt++;
    done_exp = 0;
    if (cmd_valid && cmd_ready) begin
      cmd_seen = 1;
      if (cmd_len == '0) done_exp = 1;
    end
    if (m_axis_tvalid) valid_cycles++;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
      else chk("beat", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(exp_q.pop_front()));
      if (pkt_beats == 0) first_cyc = cyc;
      pkt_beats++;
      model_stat++;
      if (m_axis_tlast) begin
        done_exp = 1;
        last_cyc = cyc;
      end
    end
    if (fifo_pop_valid && fifo_pop_ready) begin
      pop_now = 1;
      pkt_pops++;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_out = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    @(posedge clk);
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (cmd_seen) cmd_valid = 1'b0;
    m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    drive_fifo();
  endtask

  // Model: ceil(len/8) words, all lanes but the last enabled, tlast on the final beat.
  task automatic send_pkt(input int len);
    int nb;
    logic [DW-1:0] w;
    nb = (len + KW - 1) / KW;
    for (int i = 0; i < nb; i++) begin
      w = {$urandom, $urandom};
      fifo_q.push_back(w);
      if (i == nb - 1) exp_q.push_back({w, model_last_keep(len), 1'b1});
      else exp_q.push_back({w, 8'hFF, 1'b0});
    end
    pkt_beats = 0;
    pkt_pops = 0;
    valid_cycles = 0;
    cmd_len = LW'(len);
    cmd_valid = 1'b1;
    drive_fifo();
  endtask

  task automatic wait_pkt(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, 128'(done_cnt - start), 128'(1));
    chk({tag, "_exp_empty"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    done_exp = 0;
    prev_stall = 0;
    model_stat = 0;
    cmd_valid = 1'b0;
    fifo_pop_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = '0;
    fifo_pop_valid = 1'b0;
    fifo_pop_data = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_pop_ready", 128'(fifo_pop_ready), 128'(0));
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
    chk("rst_tkeep", 128'(m_axis_tkeep), 128'(0));
    chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_stat", 128'(stat_beats), 128'(0));
    chk("rst_state", 128'(o_dbg_state), 128'(0));
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;

    // 24 bytes, preloaded FIFO, sink always ready
    send_pkt(24);
    wait_pkt("t1", 200);
    chk("t1_beats", 128'(pkt_beats), 128'(3));
    chk("t1_pops", 128'(pkt_pops), 128'(3));
    chk("t1_span", 128'(last_cyc - first_cyc), 128'(2));
    chk("t1_stat", 128'(stat_beats), 128'(exp_stat()));
    chk("t1_idle", 128'(busy), 128'(0));

    // 13 bytes: partial last beat
    send_pkt(13);
    wait_pkt("t2", 200);
    chk("t2_beats", 128'(pkt_beats), 128'(2));
    chk("t2_pops", 128'(pkt_pops), 128'(2));

    // zero length: done only
    send_pkt(0);
    wait_pkt("t3", 50);
    repeat (3) step();
    chk("t3_no_valid", 128'(valid_cycles), 128'(0));
    chk("t3_pops", 128'(pkt_pops), 128'(0));
    chk("t3_cmd_ready", 128'(cmd_ready), 128'(1));

    // 64 bytes with random backpressure and FIFO bubbles
    rand_ready = 1;
    rand_gaps = 1;
    send_pkt(64);
    wait_pkt("t4", 1000);
    chk("t4_beats", 128'(pkt_beats), 128'(8));
    chk("t4_pops", 128'(pkt_pops), 128'(8));
    rand_ready = 0;
    rand_gaps = 0;
    step();

    // reset after beat 2 of 4
    send_pkt(32);
    n = 0;
    while (pkt_beats < 2 && n < 200) begin
      step();
      n++;
    end
    chk("t5_beat2_reached", 128'(pkt_beats), 128'(2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    chk("t5_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("t5_stat", 128'(stat_beats), 128'(0));
    m_axis_tready = 1'b1;
    send_pkt(8);
    wait_pkt("t5b", 200);
    chk("t5b_beats", 128'(pkt_beats), 128'(1));
    chk("t5b_pops", 128'(pkt_pops), 128'(1));

    // three 24-byte packets from a fresh reset, mixed randomness
    do_reset();
    m_axis_tready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      rand_ready = (p == 1);
      rand_gaps = (p == 2);
      send_pkt(24);
      wait_pkt("t6", 500);
      chk("t6_pops", 128'(pkt_pops), 128'(3));
    end
    chk("t6_stat", 128'(stat_beats), 128'(exp_stat()));
`ifdef MM2S_AXIS_TX_STATS_EN
    chk("t6_stat_nine", 128'(stat_beats), 128'(9));
`else
    chk("t6_stat_zero", 128'(stat_beats), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
